// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC result path.
package cordic_pkg;

    localparam int WORD_W = 48;
    localparam int TAG_W  = 16;
    localparam int VAL_W  = 32;

    localparam logic [TAG_W-1:0] TAG_SIN  = 16'h000a;
    localparam logic [TAG_W-1:0] TAG_TAN  = 16'h000b;
    localparam logic [TAG_W-1:0] TAG_COS  = 16'h000c;
    localparam logic [TAG_W-1:0] TAG_SQRT = 16'h000d;
    localparam logic [TAG_W-1:0] TAG_EXP  = 16'h000e;
    localparam logic [TAG_W-1:0] TAG_LN   = 16'h000f;

    // Serializer states: waiting for a word, or streaming bytes.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/result_fifo.sv
// Circular-buffer FIFO with registered level/full/empty and drop detect.
// A push is accepted while full only if a pop happens in the same cycle.
module result_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic [LW-1:0]    w_level_next;

    assign w_push    = i_wr_en && (!r_full || i_pop);
    assign o_drop    = i_wr_en && r_full && !i_pop;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_level   = r_level;
    assign o_full    = r_full;
    assign o_empty   = r_empty;

    // Next occupancy: simultaneous push and pop leaves the level unchanged.
    always_comb begin
        w_level_next = r_level;
        if (w_push && !i_pop) begin
            w_level_next = r_level + LW'(1);
        end else if (!w_push && i_pop) begin
            w_level_next = r_level - LW'(1);
        end
    end

    // Pointers, level and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_next;
            r_full  <= (w_level_next == LW'(DEPTH));
            r_empty <= (w_level_next == '0);
        end
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/cordic_result_serializer.sv
// Buffers 48-bit tagged CORDIC results and streams them out MSB-first as
// six bytes per word on a valid/ready byte interface, flagging dropped words.
module cordic_result_serializer
    import cordic_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_wr_en,
    input  logic [WORD_W-1:0]        in_wr_data,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     fifo_full,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    ser_state_t        r_state;
    ser_state_t        w_state_next;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] w_shift_next;
    logic [2:0]        r_idx;
    logic [2:0]        w_idx_next;
    logic              r_overflow;

    logic              w_pop;
    logic              w_xfer;
    logic [WORD_W-1:0] w_head;
    logic              w_empty;
    logic              w_drop;

    result_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (in_wr_en),
        .i_wr_data (in_wr_data),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_level   (fifo_level),
        .o_full    (fifo_full),
        .o_empty   (w_empty),
        .o_drop    (w_drop)
    );

    assign w_xfer    = (r_state == S_SEND) && out_ready;
    assign out_valid = (r_state == S_SEND);
    assign out_data  = r_shift[WORD_W-1 -: 8];
    assign overflow  = r_overflow;

    // Next-state logic: load a word when idle, shift on each accepted byte,
    // and chain straight into the next word after the sixth byte.
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_idx_next   = r_idx;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_idx_next   = '0;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (w_xfer) begin
                    if (r_idx < 3'd5) begin
                        w_shift_next = {r_shift[WORD_W-9:0], 8'h00};
                        w_idx_next   = r_idx + 3'd1;
                    end else if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_idx_next   = '0;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Serializer state, shift register and byte index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_idx   <= w_idx_next;
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cordic_result_serializer.sv
// Self-checking bench: directed scenarios plus a random phase, all checked
// against a queue-based reference model of the word FIFO and byte stream.
module tb_cordic_result_serializer;
    import cordic_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_wr_en;
    logic [47:0] in_wr_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [$clog2(DEPTH):0] fifo_level;
    logic        fifo_full;
    logic        overflow;
    logic        ovf_clr;

    cordic_result_serializer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_wr_en   (in_wr_en),
        .in_wr_data (in_wr_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: words waiting in the FIFO, bytes left of the word
    // currently presented, and the sticky overflow flag.
    logic [47:0] m_fifo[$];
    logic [7:0]  m_cur[$];
    logic        m_ovf;

    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];
    int          peak;
    logic        hold_pend;
    logic [7:0]  hold_val;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_cur.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_edge();
        logic        busy, xfer, last, full, pop, drop;
        logic [47:0] w;
        busy = (m_cur.size() != 0);
        xfer = busy && out_ready;
        last = xfer && (m_cur.size() == 1);
        full = (m_fifo.size() == DEPTH);
        pop  = (m_fifo.size() != 0) && (!busy || last);
        drop = in_wr_en && full && !pop;
        if (xfer) void'(m_cur.pop_front());
        if (pop) begin
            w = m_fifo.pop_front();
            for (int i = 0; i < 6; i++) m_cur.push_back(w[47 - 8*i -: 8]);
        end
        if (in_wr_en && !drop) m_fifo.push_back(in_wr_data);
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
    endtask

    task automatic check_all();
        logic mv;
        mv = (m_cur.size() != 0);
        chk("valid", 48'(out_valid), 48'(mv));
        if (mv) chk("data", 48'(out_data), 48'(m_cur[0]));
        chk("level", 48'(fifo_level), 48'(m_fifo.size()));
        chk("full", 48'(fifo_full), 48'(m_fifo.size() == DEPTH));
        chk("overflow", 48'(overflow), 48'(m_ovf));
    endtask

    task automatic step(input logic wr, input logic [47:0] d, input logic rdy, input logic clr);
        in_wr_en = wr; in_wr_data = d; out_ready = rdy; ovf_clr = clr;
        #1;
        if (out_valid && out_ready) got.push_back(out_data);
        hold_pend = out_valid && !out_ready;
        hold_val  = out_data;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (hold_pend && out_valid) chk("stable", 48'(out_data), 48'(hold_val));
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
    endtask

    task automatic add_word(input logic [47:0] w);
        for (int i = 0; i < 6; i++) exp_q.push_back(w[47 - 8*i -: 8]);
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_count"}, 48'(got.size()), 48'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk({tag, "_byte"}, 48'(got[i]), 48'(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_wr_en = 1'b0; ovf_clr = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_data", 48'(out_data), 48'h0);
        chk("rst_valid", 48'(out_valid), 48'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        got.delete();
        exp_q.delete();
    endtask

    logic [47:0] w;
    logic [47:0] burst [3];
    logic [7:0]  sw_bytes [6];

    initial begin
        reset = 1'b1; in_wr_en = 1'b0; in_wr_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        hold_pend = 1'b0; hold_val = '0; peak = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_data", 48'(out_data), 48'h0);
        reset = 1'b0;

        // Single word: 00 0A 3F 80 00 00 on consecutive cycles, 2-cycle latency.
        step(1'b1, {TAG_SIN, 32'h3F80_0000}, 1'b1, 1'b0);
        chk("sw_level1", 48'(fifo_level), 48'd1);
        chk("sw_not_yet_valid", 48'(out_valid), 48'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("sw_valid_latency", 48'(out_valid), 48'd1);
        repeat (7) step(1'b0, '0, 1'b1, 1'b0);
        sw_bytes = '{8'h00, 8'h0A, 8'h3F, 8'h80, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) exp_q.push_back(sw_bytes[i]);
        cmp_stream("single");

        // Tanh burst: three back-to-back words, 18 contiguous bytes, peak level 2.
        burst = '{{TAG_SIN, 32'h0000_1111}, {TAG_COS, 32'h0000_2222}, {TAG_TAN, 32'h0000_3333}};
        peak = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, burst[i], 1'b1, 1'b0);
            add_word(burst[i]);
        end
        repeat (20) step(1'b0, '0, 1'b1, 1'b0);
        chk("tanh_peak_level", 48'(peak), 48'd2);
        cmp_stream("tanh");

        // Backpressure: ready pattern 1,0,0 repeating.
        w = {TAG_SQRT, $urandom()};
        step(1'b1, w, 1'b1, 1'b0);
        add_word(w);
        for (int k = 0; k < 24; k++) step(1'b0, '0, 1'((k % 3) == 0), 1'b0);
        cmp_stream("backpressure");

        // Overflow: word 1 moves into the shift register, words 2-5 fill the
        // FIFO, so the sixth strobe is the one dropped.
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, {TAG_EXP, 32'(i)}, 1'b0, 1'b0);
            if (i <= 5) add_word({TAG_EXP, 32'(i)});
        end
        chk("ovf_full", 48'(fifo_full), 48'd1);
        chk("ovf_set", 48'(overflow), 48'd1);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("ovf_sticky", 48'(overflow), 48'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_cleared", 48'(overflow), 48'd0);

        // Full FIFO with a strobe on the last-byte pop: accepted, no overflow.
        repeat (5) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, {TAG_LN, 32'hCAFE_F00D}, 1'b1, 1'b0);
        add_word({TAG_LN, 32'hCAFE_F00D});
        chk("simul_level", 48'(fifo_level), 48'(DEPTH));
        chk("simul_no_ovf", 48'(overflow), 48'd0);
        repeat (36) step(1'b0, '0, 1'b1, 1'b0);
        cmp_stream("overflow_drain");

        // Reset after byte 3 of a word with two more words queued.
        for (int i = 0; i < 3; i++) step(1'b1, {TAG_COS, $urandom()}, 1'b0, 1'b0);
        chk("mid_level2", 48'(fifo_level), 48'd2);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        do_reset();
        repeat (10) step(1'b0, '0, 1'b1, 1'b0);
        chk("post_rst_silent", 48'(got.size()), 48'd0);
        w = 48'h0;
        step(1'b1, w, 1'b1, 1'b0);
        add_word(w);
        repeat (8) step(1'b0, '0, 1'b1, 1'b0);
        cmp_stream("post_rst_zero_word");

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 4) == 0), {$urandom_range(10, 15), $urandom()},
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
